// File: rtl/thumb_encoder.sv
// Micro-op to Thumb-16 encoder: one request in, one or more halfwords out.
// Wide MOV immediates expand into a MOV/LSL/ADD sequence.
module thumb_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_uop,
    input  logic [2:0]  req_rd,
    input  logic [2:0]  req_rn,
    input  logic [2:0]  req_rm,
    input  logic        req_use_imm,
    input  logic [31:0] req_imm,
    input  logic [3:0]  req_cond,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_instr,
    output logic        out_last,
    output logic        err
);

    localparam logic [4:0] UOP_B   = 5'd0;
    localparam logic [4:0] UOP_ADD = 5'd1;
    localparam logic [4:0] UOP_SUB = 5'd2;
    localparam logic [4:0] UOP_EOR = 5'd4;
    localparam logic [4:0] UOP_CMP = 5'd5;
    localparam logic [4:0] UOP_LSL = 5'd6;
    localparam logic [4:0] UOP_MOV = 5'd8;
    localparam logic [4:0] UOP_STR = 5'd9;
    localparam logic [4:0] UOP_LDR = 5'd10;

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t      state;
    logic [31:0] imm_q;
    logic [2:0]  rd_q;
    logic [1:0]  idx;
    logic        step;

    logic [15:0] enc;
    logic        bad;
    logic        expand;
    logic [1:0]  k;
    logic [7:0]  top_byte;
    logic [7:0]  cur_byte;
    logic        lt256;
    logic        lt8;
    logic        lt32;
    logic        b_ok;
    logic        bc_ok;
    logic        is_sub;

    assign req_ready = (state == IDLE) && !reset;

    assign lt256  = (req_imm[31:8] == 24'd0);
    assign lt8    = (req_imm[31:3] == 29'd0);
    assign lt32   = (req_imm[31:5] == 27'd0);
    assign b_ok   = (&req_imm[31:10]) || !(|req_imm[31:10]);
    assign bc_ok  = (&req_imm[31:7]) || !(|req_imm[31:7]);
    assign is_sub = (req_uop == UOP_SUB);

    // Index of the most significant nonzero byte; only meaningful above 255.
    always_comb begin
        k        = 2'd1;
        top_byte = req_imm[15:8];
        if (req_imm[31:24] != 8'd0) begin
            k        = 2'd3;
            top_byte = req_imm[31:24];
        end else if (req_imm[23:16] != 8'd0) begin
            k        = 2'd2;
            top_byte = req_imm[23:16];
        end
    end

    always_comb begin
        cur_byte = imm_q[7:0];
        case (idx)
            2'd0: cur_byte = imm_q[7:0];
            2'd1: cur_byte = imm_q[15:8];
            2'd2: cur_byte = imm_q[23:16];
            2'd3: cur_byte = imm_q[31:24];
            default: cur_byte = imm_q[7:0];
        endcase
    end

    always_comb begin
        enc    = 16'h0000;
        bad    = 1'b0;
        expand = 1'b0;
        case (req_uop)
            UOP_ADD, UOP_SUB: begin
                if (!req_use_imm) begin
                    enc = {(is_sub ? 7'b0001101 : 7'b0001100),
                           req_rm, req_rn, req_rd};
                end else if (req_rd == req_rn && lt256) begin
                    enc = {(is_sub ? 5'b00111 : 5'b00110),
                           req_rd, req_imm[7:0]};
                end else if (lt8) begin
                    enc = {(is_sub ? 7'b0001111 : 7'b0001110),
                           req_imm[2:0], req_rn, req_rd};
                end else begin
                    bad = 1'b1;
                end
            end
            UOP_MOV: begin
                if (!req_use_imm) begin
                    enc = {10'b0000000000, req_rm, req_rd};
                end else if (lt256) begin
                    enc = {5'b00100, req_rd, req_imm[7:0]};
                end else begin
                    expand = 1'b1;
                end
            end
            UOP_LSL: begin
                if (lt32) enc = {5'b00000, req_imm[4:0], req_rm, req_rd};
                else      bad = 1'b1;
            end
            UOP_CMP: begin
                if (lt256) enc = {5'b00101, req_rn, req_imm[7:0]};
                else       bad = 1'b1;
            end
            UOP_EOR: begin
                enc = {10'b0100000001, req_rm, req_rd};
            end
            UOP_STR: begin
                if (lt32) enc = {5'b01100, req_imm[4:0], req_rn, req_rd};
                else      bad = 1'b1;
            end
            UOP_LDR: begin
                if (lt32) enc = {5'b01101, req_imm[4:0], req_rn, req_rd};
                else      bad = 1'b1;
            end
            UOP_B: begin
                if (req_cond == 4'b1111) begin
                    bad = 1'b1;
                end else if (req_cond == 4'b1110) begin
                    if (b_ok) enc = {5'b11100, req_imm[10:0]};
                    else      bad = 1'b1;
                end else begin
                    if (bc_ok) enc = {4'b1101, req_cond, req_imm[7:0]};
                    else       bad = 1'b1;
                end
            end
            default: bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_instr <= 16'h0000;
            out_last  <= 1'b0;
            err       <= 1'b0;
            imm_q     <= 32'd0;
            rd_q      <= 3'd0;
            idx       <= 2'd0;
            step      <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (bad) begin
                            err <= 1'b1;
                        end else if (expand) begin
                            out_valid <= 1'b1;
                            out_instr <= {5'b00100, req_rd, top_byte};
                            out_last  <= 1'b0;
                            imm_q     <= req_imm;
                            rd_q      <= req_rd;
                            idx       <= k - 2'd1;
                            step      <= 1'b0;
                            state     <= EMIT;
                        end else begin
                            out_valid <= 1'b1;
                            out_instr <= enc;
                            out_last  <= 1'b1;
                            state     <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            idx       <= 2'd0;
                            step      <= 1'b0;
                            state     <= IDLE;
                        end else if (!step) begin
                            // LSL rd, rd, #8 ahead of byte[idx]
                            out_instr <= {5'b00000, 5'd8, rd_q, rd_q};
                            out_last  <= (cur_byte == 8'd0) && (idx == 2'd0);
                            if (cur_byte != 8'd0) step <= 1'b1;
                            else                  idx  <= idx - 2'd1;
                        end else begin
                            out_instr <= {5'b00110, rd_q, cur_byte};
                            out_last  <= (idx == 2'd0);
                            step      <= 1'b0;
                            idx       <= idx - 2'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_thumb_encoder.sv
// Directed self-checking bench for thumb_encoder.
// Inputs change on falling edges; outputs are sampled on falling edges.
module tb_thumb_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_uop;
    logic [2:0]  req_rd;
    logic [2:0]  req_rn;
    logic [2:0]  req_rm;
    logic        req_use_imm;
    logic [31:0] req_imm;
    logic [3:0]  req_cond;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic        out_last;
    logic        err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    thumb_encoder dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_uop(req_uop),
        .req_rd(req_rd),
        .req_rn(req_rn),
        .req_rm(req_rm),
        .req_use_imm(req_use_imm),
        .req_imm(req_imm),
        .req_cond(req_cond),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_last(out_last),
        .err(err)
    );

    // Returns at the falling edge right after the accepting edge.
    task automatic drive_req(input logic [4:0] uop, input logic [2:0] rd,
                             input logic [2:0] rn, input logic [2:0] rm,
                             input logic ui, input logic [31:0] imm,
                             input logic [3:0] cond);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL req_ready_timeout got=%b want=1", req_ready);
        end
        req_uop = uop; req_rd = rd; req_rn = rn; req_rm = rm;
        req_use_imm = ui; req_imm = imm; req_cond = cond;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        req_imm = 32'hDEAD_BEEF;
        req_rd = 3'd5;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin failures++;
            $display("FAIL rst_req_ready got=%b want=0", req_ready); end
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL rst_flags got=%b%b%b want=000",
                     out_valid, out_last, err);
        end
        checks++;
        if (out_instr !== 16'h0000) begin failures++;
            $display("FAIL rst_instr got=%h want=0000", out_instr); end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin failures++;
            $display("FAIL rst_release_ready got=%b want=1", req_ready); end
    endtask

    task automatic test_add_reg();
        out_ready = 1'b1;
        drive_req(5'd1, 3'd1, 3'd2, 3'd3, 1'b0, 32'd0, 4'he);
        checks++;
        if (out_valid !== 1'b1 || out_instr !== 16'h18D1 || out_last !== 1'b1)
        begin
            failures++;
            $display("FAIL add_reg got=%b/%h/%b want=1/18d1/1",
                     out_valid, out_instr, out_last);
        end
        checks++;
        if (req_ready !== 1'b0) begin failures++;
            $display("FAIL add_reg_busy got=%b want=0", req_ready); end
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || out_valid !== 1'b0) begin failures++;
            $display("FAIL add_reg_done got=%b/%b want=1/0",
                     req_ready, out_valid);
        end
    endtask

    task automatic test_mov_expand();
        logic [15:0] exp_q[$];
        logic [31:0] imm;
        logic [2:0]  rd;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (c == 0) begin
                imm = 32'h1200_3400; rd = 3'd2;
                exp_q = '{16'h2212, 16'h0212, 16'h0212, 16'h3234, 16'h0212};
            end else if (c == 1) begin
                imm = 32'h0000_0100; rd = 3'd0;
                exp_q = '{16'h2001, 16'h0200};
            end else begin
                imm = 32'hFFFF_FFFF; rd = 3'd7;
                exp_q = '{16'h27FF, 16'h023F, 16'h37FF, 16'h023F,
                          16'h37FF, 16'h023F, 16'h37FF};
            end
            drive_req(5'd8, rd, 3'd0, 3'd0, 1'b1, imm, 4'he);
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (out_valid !== 1'b1 || out_instr !== exp_q[i] ||
                    out_last !== (i == exp_q.size() - 1)) begin
                    failures++;
                    $display("FAIL mov_seq%0d[%0d] got=%b/%h/%b want=1/%h/%b",
                             c, i, out_valid, out_instr, out_last, exp_q[i],
                             (i == exp_q.size() - 1));
                end
                @(negedge clk);
            end
            checks++;
            if (out_valid !== 1'b0 || req_ready !== 1'b1) begin failures++;
                $display("FAIL mov_seq%0d_end got=%b/%b want=0/1",
                         c, out_valid, req_ready);
            end
        end
    endtask

    task automatic test_mov_stall();
        logic [15:0] exp_q[$];
        exp_q = '{16'h2212, 16'h0212, 16'h0212, 16'h3234, 16'h0212};
        out_ready = 1'b1;
        drive_req(5'd8, 3'd2, 3'd0, 3'd0, 1'b1, 32'h1200_3400, 4'he);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    checks++;
                    if (out_valid !== 1'b1 || out_instr !== 16'h0212 ||
                        out_last !== 1'b0 || req_ready !== 1'b0) begin
                        failures++;
                        $display("FAIL stall[%0d] got=%b/%h/%b/%b want=1/0212/0/0",
                                 s, out_valid, out_instr, out_last, req_ready);
                    end
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
            checks++;
            if (out_valid !== 1'b1 || out_instr !== exp_q[i] ||
                out_last !== (i == 4) || req_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_seq[%0d] got=%b/%h/%b want=1/%h/%b",
                         i, out_valid, out_instr, out_last, exp_q[i], (i == 4));
            end
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b0 || req_ready !== 1'b1) begin failures++;
            $display("FAIL stall_end got=%b/%b want=0/1", out_valid, req_ready);
        end
    endtask

    task automatic test_encodings();
        logic [4:0]  t_uop[14];
        logic [2:0]  t_rd[14];
        logic [2:0]  t_rn[14];
        logic [2:0]  t_rm[14];
        logic        t_ui[14];
        logic [31:0] t_imm[14];
        logic [3:0]  t_cond[14];
        logic [15:0] t_exp[14];
        logic        t_err[14];
        t_uop = '{5'd0, 5'd0, 5'd0, 5'd5, 5'd1, 5'd1, 5'd8, 5'd8,
                  5'd10, 5'd9, 5'd9, 5'd4, 5'd6, 5'd2};
        t_rd  = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd3, 3'd1,
                  3'd1, 3'd7, 3'd7, 3'd5, 3'd1, 3'd0};
        t_rn  = '{3'd0, 3'd0, 3'd0, 3'd4, 3'd1, 3'd1, 3'd0, 3'd0,
                  3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
        t_rm  = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd6,
                  3'd0, 3'd0, 3'd0, 3'd6, 3'd2, 3'd0};
        t_ui  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        t_imm = '{32'hFFFF_FFFD, 32'h0000_03FF, 32'h0000_0400, 32'd300,
                  32'd9, 32'd9, 32'h0000_00FF, 32'd0, 32'd4, 32'd31,
                  32'd32, 32'd0, 32'd3, 32'd5};
        t_cond = '{4'h0, 4'he, 4'he, 4'he, 4'he, 4'he, 4'he, 4'he,
                   4'he, 4'he, 4'he, 4'he, 4'he, 4'he};
        t_exp = '{16'hD0FD, 16'hE3FF, 16'h0000, 16'h0000, 16'h0000,
                  16'h3109, 16'h23FF, 16'h0031, 16'h6911, 16'h67C7,
                  16'h0000, 16'h4075, 16'h00D1, 16'h1F48};
        t_err = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            drive_req(t_uop[i], t_rd[i], t_rn[i], t_rm[i], t_ui[i],
                      t_imm[i], t_cond[i]);
            if (t_err[i]) begin
                checks++;
                if (err !== 1'b1 || out_valid !== 1'b0) begin failures++;
                    $display("FAIL enc[%0d]_err got=%b/%b want=1/0",
                             i, err, out_valid);
                end
                @(negedge clk);
                checks++;
                if (err !== 1'b0 || out_valid !== 1'b0 || req_ready !== 1'b1)
                begin
                    failures++;
                    $display("FAIL enc[%0d]_err_pulse got=%b/%b/%b want=0/0/1",
                             i, err, out_valid, req_ready);
                end
            end else begin
                checks++;
                if (out_valid !== 1'b1 || out_instr !== t_exp[i] ||
                    out_last !== 1'b1 || err !== 1'b0) begin
                    failures++;
                    $display("FAIL enc[%0d] got=%b/%h/%b/%b want=1/%h/1/0",
                             i, out_valid, out_instr, out_last, err, t_exp[i]);
                end
            end
        end
    endtask

    task automatic test_more_errors();
        logic [4:0]  e_uop[5];
        logic [31:0] e_imm[5];
        logic [3:0]  e_cond[5];
        e_uop  = '{5'd3, 5'd0, 5'd0, 5'd6, 5'd10};
        e_imm  = '{32'd0, 32'd0, 32'h0000_0080, 32'd32, 32'd40};
        e_cond = '{4'he, 4'hf, 4'h1, 4'he, 4'he};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_req(e_uop[i], 3'd1, 3'd2, 3'd3, 1'b1, e_imm[i], e_cond[i]);
            checks++;
            if (err !== 1'b1 || out_valid !== 1'b0) begin failures++;
                $display("FAIL err_case[%0d] got=%b/%b want=1/0",
                         i, err, out_valid);
            end
        end
        drive_req(5'd0, 3'd0, 3'd0, 3'd0, 1'b1, 32'hFFFF_FF80, 4'h1);
        checks++;
        if (out_valid !== 1'b1 || out_instr !== 16'hD180) begin failures++;
            $display("FAIL bcond_min got=%b/%h want=1/d180",
                     out_valid, out_instr);
        end
        drive_req(5'd2, 3'd2, 3'd2, 3'd0, 1'b1, 32'd200, 4'he);
        checks++;
        if (out_valid !== 1'b1 || out_instr !== 16'h3AC8) begin failures++;
            $display("FAIL sub_imm8 got=%b/%h want=1/3ac8",
                     out_valid, out_instr);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        drive_req(5'd8, 3'd2, 3'd0, 3'd0, 1'b1, 32'h1200_3400, 4'he);
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_instr !== 16'h0212) begin failures++;
            $display("FAIL mid_third got=%b/%h want=1/0212",
                     out_valid, out_instr);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || err !== 1'b0 || out_instr !== 16'h0000 ||
            req_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got=%b/%b/%h/%b want=0/0/0000/0",
                     out_valid, err, out_instr, req_ready);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || out_valid !== 1'b0) begin failures++;
            $display("FAIL mid_release got=%b/%b want=1/0",
                     req_ready, out_valid);
        end
        drive_req(5'd1, 3'd1, 3'd2, 3'd3, 1'b0, 32'd0, 4'he);
        checks++;
        if (out_valid !== 1'b1 || out_instr !== 16'h18D1 || out_last !== 1'b1)
        begin
            failures++;
            $display("FAIL mid_after got=%b/%h/%b want=1/18d1/1",
                     out_valid, out_instr, out_last);
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0;
        req_uop = 5'd0;
        req_rd = 3'd0;
        req_rn = 3'd0;
        req_rm = 3'd0;
        req_use_imm = 1'b0;
        req_imm = 32'd0;
        req_cond = 4'he;
        out_ready = 1'b1;
        test_reset();
        test_add_reg();
        test_mov_expand();
        test_mov_stall();
        test_encodings();
        test_more_errors();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
